// File: rtl/frame_aligner.sv
// Frame aligner: slides a 40-bit window across the deserialized stream until the
// header repeats at one bit offset, then holds that offset until headers stop.
module frame_aligner #(
    parameter logic [15:0] HEADER     = 16'h3C5C,
    parameter int          LOCK_COUNT = 4,
    parameter int          DWELL      = 64,
    parameter int          TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [39:0] dataIn,
    output logic [39:0] dataOut,
    output logic        dataValid,
    output logic        aligned,
    output logic [5:0]  bitOffset,
    output logic        headerFound,
    output logic [7:0]  lossCount
);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t      state_q, state_d;
    logic [39:0] prevWord_q;
    logic [39:0] dataOut_q;
    logic [5:0]  offset_q, offset_d, offsetNext;
    logic [7:0]  gap_q, gap_d;
    logic [7:0]  matchCnt_q, matchCnt_d;
    logic [7:0]  loss_q, loss_d;
    logic        valid_q, valid_d;
    logic        found_q;

    logic [79:0] stream;
    logic [6:0]  winTop;
    logic [39:0] window;
    logic        match;
    logic        dwellHit;
    logic        timeoutHit;

    // Offset 0 selects the previous word; each step moves one bit later in time.
    assign stream     = {prevWord_q, dataIn};
    assign winTop     = 7'd79 - {1'b0, offset_q};
    assign window     = stream[winTop -: 40];
    assign match      = (window[39:24] == HEADER);
    assign dwellHit   = (gap_q == 8'(DWELL - 1));
    assign timeoutHit = (gap_q == 8'(TIMEOUT - 1));
    assign offsetNext = (offset_q == 6'd39) ? 6'd0 : offset_q + 6'd1;

    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        matchCnt_d = matchCnt_q;
        loss_d     = loss_q;
        gap_d      = (gap_q == 8'hFF) ? gap_q : gap_q + 8'd1;
        if (match) begin
            gap_d = 8'd0;
        end

        // A match always wins over a gap limit reached in the same cycle.
        case (state_q)
            SEARCH: begin
                if (match) begin
                    state_d    = (LOCK_COUNT <= 1) ? LOCKED : VERIFY;
                    matchCnt_d = 8'd1;
                end else if (dwellHit) begin
                    offset_d = offsetNext;
                    gap_d    = 8'd0;
                end
            end
            VERIFY: begin
                if (match) begin
                    matchCnt_d = matchCnt_q + 8'd1;
                    if (matchCnt_q + 8'd1 >= 8'(LOCK_COUNT)) begin
                        state_d = LOCKED;
                    end
                end else if (dwellHit) begin
                    state_d    = SEARCH;
                    offset_d   = offsetNext;
                    gap_d      = 8'd0;
                    matchCnt_d = 8'd0;
                end
            end
            LOCKED: begin
                if (!match && timeoutHit) begin
                    state_d    = SEARCH;
                    offset_d   = offsetNext;
                    gap_d      = 8'd0;
                    matchCnt_d = 8'd0;
                    loss_d     = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase

        // Only frames compared and kept inside LOCKED are flagged valid.
        valid_d = (state_q == LOCKED) && (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SEARCH;
            offset_q   <= 6'd0;
            gap_q      <= 8'd0;
            matchCnt_q <= 8'd0;
            loss_q     <= 8'd0;
            prevWord_q <= 40'd0;
            dataOut_q  <= 40'd0;
            valid_q    <= 1'b0;
            found_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            gap_q      <= gap_d;
            matchCnt_q <= matchCnt_d;
            loss_q     <= loss_d;
            prevWord_q <= dataIn;
            dataOut_q  <= window;
            valid_q    <= valid_d;
            found_q    <= match;
        end
    end

    assign dataOut     = dataOut_q;
    assign dataValid   = valid_q;
    assign aligned     = (state_q == LOCKED);
    assign bitOffset   = offset_q;
    assign headerFound = found_q;
    assign lossCount   = loss_q;

endmodule

// File: tb/tb_frame_aligner.sv
// Directed bench for frame_aligner: builds a bit-delayed frame stream and checks
// lock timing, slips, timeouts, offset wrap, saturation and reset behaviour.
`timescale 1ns/1ps
module tb_frame_aligner;

    localparam logic [15:0] HDR = 16'h3C5C;

    logic        clk = 1'b0;
    logic        reset;
    logic [39:0] dataIn;
    logic [39:0] dataOut;
    logic        dataValid;
    logic        aligned;
    logic [5:0]  bitOffset;
    logic        headerFound;
    logic [7:0]  lossCount;

    always #5 clk = ~clk;

    frame_aligner dut (
        .clk        (clk),
        .reset      (reset),
        .dataIn     (dataIn),
        .dataOut    (dataOut),
        .dataValid  (dataValid),
        .aligned    (aligned),
        .bitOffset  (bitOffset),
        .headerFound(headerFound),
        .lossCount  (lossCount)
    );

    int          checks   = 0;
    int          failures = 0;
    int          d        = 0;
    int          P        = 8;
    bit          hdr_on   = 1'b0;
    int          fidx     = 0;
    logic [39:0] prev_f   = '0;
    bit          prev_h   = 1'b0;
    logic [39:0] exp_out  = '0;
    bit          exp_hdr  = 1'b0;

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Header frames carry an isolated id byte; other frames carry one low byte.
    // Neither can form the header at any bit shift of the stream.
    task automatic send();
        bit          h;
        logic [39:0] cur;
        logic [79:0] both;
        h      = hdr_on && (fidx % P == 0);
        cur    = h ? {HDR, 8'h00, 8'(fidx), 8'h00} : {32'h0, 8'(fidx)};
        both   = {prev_f, cur} >> d;
        dataIn = both[39:0];
        @(posedge clk);
        #1;
        exp_out = prev_f;
        exp_hdr = prev_h;
        prev_f  = cur;
        prev_h  = h;
        fidx++;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        send();
        reset  = 1'b0;
        prev_f = '0;
        prev_h = 1'b0;
        fidx   = 0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_dataOut"}, dataOut, 40'd0);
        chk({tag, "_dataValid"}, 40'(dataValid), 40'd0);
        chk({tag, "_aligned"}, 40'(aligned), 40'd0);
        chk({tag, "_bitOffset"}, 40'(bitOffset), 40'd0);
        chk({tag, "_headerFound"}, 40'(headerFound), 40'd0);
        chk({tag, "_lossCount"}, 40'(lossCount), 40'd0);
    endtask

    task automatic lock_at_zero(input string tag);
        int pulses;
        pulses = 0;
        d      = 0;
        P      = 8;
        hdr_on = 1'b1;
        for (int e = 0; e <= 26; e++) begin
            send();
            chk({tag, "_data"}, dataOut, exp_out);
            chk({tag, "_hf"}, 40'(headerFound), 40'(exp_hdr));
            if (headerFound) pulses++;
            if (e == 24) chk({tag, "_prelock"}, 40'(aligned), 40'd0);
            if (e == 25) begin
                chk({tag, "_lock"}, 40'(aligned), 40'd1);
                chk({tag, "_pulses"}, 40'(pulses), 40'd4);
                chk({tag, "_offset"}, 40'(bitOffset), 40'd0);
                chk({tag, "_valid_first"}, 40'(dataValid), 40'd0);
            end
            if (e == 26) chk({tag, "_valid"}, 40'(dataValid), 40'd1);
        end
    endtask

    task automatic wait_aligned(input bit want, input int bound, input string tag);
        int n;
        n = 0;
        while (aligned !== want && n < bound) begin
            send();
            n++;
        end
        chk(tag, 40'(aligned), 40'(want));
    endtask

    task automatic drop(input string tag);
        hdr_on = 1'b0;
        wait_aligned(1'b0, 300, tag);
    endtask

    task automatic relock(input string tag);
        d      = (d + 1) % 40;
        P      = 2;
        hdr_on = 1'b1;
        wait_aligned(1'b1, 100, tag);
    endtask

    initial begin
        int e;
        reset  = 1'b1;
        dataIn = '0;
        reset_dut();
        reset_dut();
        check_reset("rst0");

        lock_at_zero("lock0");

        // Stream delayed by 13 bits: one slip per 64 frames, then lock.
        reset_dut();
        d      = 13;
        P      = 8;
        hdr_on = 1'b1;
        while (fidx <= 900) begin
            send();
            e = fidx - 1;
            if (e == 62)  chk("d13_off_pre_slip", 40'(bitOffset), 40'd0);
            if (e == 63)  chk("d13_off_first_slip", 40'(bitOffset), 40'd1);
            if (e == 830) chk("d13_off_12", 40'(bitOffset), 40'd12);
            if (e == 831) chk("d13_off_13", 40'(bitOffset), 40'd13);
            if (e == 856) chk("d13_prelock", 40'(aligned), 40'd0);
            if (e == 857) begin
                chk("d13_lock", 40'(aligned), 40'd1);
                chk("d13_lock_off", 40'(bitOffset), 40'd13);
                chk("d13_loss0", 40'(lossCount), 40'd0);
            end
            if (e > 857) begin
                chk("d13_data", dataOut, exp_out);
                chk("d13_hf", 40'(headerFound), 40'(exp_hdr));
            end
        end

        // Last header frame is 896; timeout lands 255 frames after its match.
        hdr_on = 1'b0;
        while (fidx <= 1153) begin
            send();
            e = fidx - 1;
            if (e == 1151) begin
                chk("to_still_locked", 40'(aligned), 40'd1);
                chk("to_valid_before", 40'(dataValid), 40'd1);
            end
            if (e == 1152) begin
                chk("to_dropped", 40'(aligned), 40'd0);
                chk("to_valid_after", 40'(dataValid), 40'd0);
                chk("to_loss1", 40'(lossCount), 40'd1);
                chk("to_off14", 40'(bitOffset), 40'd14);
            end
        end

        relock("rl1");
        drop("dr2");
        relock("rl2");
        drop("dr3");
        relock("rl3");
        chk("loss3", 40'(lossCount), 40'd3);

        // Reset lands on a cycle whose window holds a header.
        for (int i = 0; i < 4 && !prev_h; i++) send();
        chk("hdr_in_window", 40'(prev_h), 40'd1);
        reset_dut();
        check_reset("rst1");
        lock_at_zero("lock1");

        for (int i = 1; i <= 256; i++) begin
            drop("sat_drop");
            if (i == 255) chk("sat_255", 40'(lossCount), 40'd255);
            if (i < 256) relock("sat_relock");
        end
        chk("sat_hold", 40'(lossCount), 40'd255);

        // Offset 39 with one header per dwell window; loss wraps offset to 0.
        reset_dut();
        d      = 39;
        P      = 64;
        hdr_on = 1'b1;
        wait_aligned(1'b1, 3000, "wrap_lock0");
        chk("wrap_off39", 40'(bitOffset), 40'd39);
        hdr_on = 1'b0;
        wait_aligned(1'b0, 300, "wrap_drop");
        chk("wrap_off0", 40'(bitOffset), 40'd0);
        chk("wrap_loss1", 40'(lossCount), 40'd1);
        hdr_on = 1'b1;
        wait_aligned(1'b1, 3200, "wrap_relock");
        chk("wrap_off39_again", 40'(bitOffset), 40'd39);
        for (int i = 0; i < 10; i++) begin
            send();
            chk("wrap_data", dataOut, exp_out);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
